// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer: request opcodes, ALU_control codes and FSM states.
package alu_seq_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        OP_AND   = 3'd0,
        OP_OR    = 3'd1,
        OP_ADD   = 3'd2,
        OP_SUB   = 3'd3,
        OP_SLT   = 3'd4,
        OP_NOR   = 3'd5,
        OP_MULLO = 3'd6,
        OP_RSVD  = 3'd7
    } op_t;

    localparam logic [3:0] CTRL_AND = 4'b0000;
    localparam logic [3:0] CTRL_OR  = 4'b0001;
    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_SUB = 4'b0110;
    localparam logic [3:0] CTRL_SLT = 4'b0111;
    localparam logic [3:0] CTRL_NOR = 4'b1100;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_MUL   = 2'd2,
        S_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Request/response handshake bundle between the issue logic (master) and the ALU sequencer (slave).
interface alu_seq_if;
    import alu_seq_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_op;
    logic [DATA_W-1:0] req_src1;
    logic [DATA_W-1:0] req_src2;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_zero;
    logic              rsp_cout;
    logic              rsp_overflow;
    logic              rsp_err;

    modport master (
        output req_valid, req_op, req_src1, req_src2, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_cout, rsp_overflow, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_src1, req_src2, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_cout, rsp_overflow, rsp_err
    );

endinterface

// File: rtl/alu_op_decode.sv
// Combinational opcode decode: ALU_control code plus multiply / reserved-op flags.
module alu_op_decode
    import alu_seq_pkg::*;
(
    input  logic [2:0] op,
    output logic [3:0] alu_ctrl,
    output logic       is_mul,
    output logic       is_err
);

    always_comb begin
        alu_ctrl = CTRL_AND;
        is_mul   = 1'b0;
        is_err   = 1'b0;
        case (op_t'(op))
            OP_AND:   alu_ctrl = CTRL_AND;
            OP_OR:    alu_ctrl = CTRL_OR;
            OP_ADD:   alu_ctrl = CTRL_ADD;
            OP_SUB:   alu_ctrl = CTRL_SUB;
            OP_SLT:   alu_ctrl = CTRL_SLT;
            OP_NOR:   alu_ctrl = CTRL_NOR;
            OP_MULLO: begin
                alu_ctrl = CTRL_ADD;
                is_mul   = 1'b1;
            end
            default:  is_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// ALU sequencer: issues single-cycle ALU ops over a valid/ready channel and runs MULLO
// as a shift-add loop through the external ALU's ADD path.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH     = DATA_W,
    parameter int MUL_STEPS = DATA_W
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_seq_if.slave         bus,
    output logic [WIDTH-1:0] alu_src1,
    output logic [WIDTH-1:0] alu_src2,
    output logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    input  logic             alu_cout,
    input  logic             alu_overflow
);

    localparam int CNT_W = $clog2(MUL_STEPS);

    state_t            state_reg, state_next;
    logic [3:0]        dec_ctrl;
    logic              dec_mul, dec_err;
    logic              accept;
    logic              last_step;
    logic [WIDTH-1:0]  src1_reg, src2_reg;
    logic [3:0]        ctrl_reg;
    logic [WIDTH-1:0]  mcand_reg, mplier_reg;
    logic [WIDTH-1:0]  mcand_shift, mplier_shift;
    logic [CNT_W-1:0]  cnt_reg;
    logic [WIDTH-1:0]  result_reg;
    logic              zero_reg, cout_reg, overflow_reg, err_reg;

    alu_op_decode u_decode (
        .op       (bus.req_op),
        .alu_ctrl (dec_ctrl),
        .is_mul   (dec_mul),
        .is_err   (dec_err)
    );

    assign accept       = bus.req_valid && bus.req_ready;
    assign last_step    = (cnt_reg == CNT_W'(MUL_STEPS - 1));
    assign mcand_shift  = mcand_reg << 1;
    assign mplier_shift = mplier_reg >> 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= S_IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    if (dec_err)      state_next = S_RESP;
                    else if (dec_mul) state_next = S_MUL;
                    else              state_next = S_ISSUE;
                end
            end
            S_ISSUE: state_next = S_RESP;
            S_MUL:   if (last_step) state_next = S_RESP;
            S_RESP:  if (bus.rsp_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = (state_reg == S_IDLE);
        bus.rsp_valid = (state_reg == S_RESP);
    end

    // ALU inputs are registered, so they already hold the values for the coming
    // ISSUE/MUL cycle; during MUL src1_reg is the running accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src1_reg     <= '0;
            src2_reg     <= '0;
            ctrl_reg     <= CTRL_AND;
            mcand_reg    <= '0;
            mplier_reg   <= '0;
            cnt_reg      <= '0;
            result_reg   <= '0;
            zero_reg     <= 1'b0;
            cout_reg     <= 1'b0;
            overflow_reg <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        if (dec_err) begin
                            result_reg   <= '0;
                            zero_reg     <= 1'b0;
                            cout_reg     <= 1'b0;
                            overflow_reg <= 1'b0;
                            err_reg      <= 1'b1;
                        end else if (dec_mul) begin
                            src1_reg   <= '0;
                            src2_reg   <= bus.req_src2[0] ? bus.req_src1 : '0;
                            ctrl_reg   <= CTRL_ADD;
                            mcand_reg  <= bus.req_src1;
                            mplier_reg <= bus.req_src2;
                            cnt_reg    <= '0;
                        end else begin
                            src1_reg <= bus.req_src1;
                            src2_reg <= bus.req_src2;
                            ctrl_reg <= dec_ctrl;
                        end
                    end
                end
                S_ISSUE: begin
                    result_reg   <= alu_result;
                    zero_reg     <= alu_zero;
                    cout_reg     <= alu_cout;
                    overflow_reg <= alu_overflow;
                    err_reg      <= 1'b0;
                end
                S_MUL: begin
                    mcand_reg  <= mcand_shift;
                    mplier_reg <= mplier_shift;
                    cnt_reg    <= cnt_reg + 1'b1;
                    if (last_step) begin
                        result_reg   <= alu_result;
                        zero_reg     <= (alu_result == '0);
                        cout_reg     <= 1'b0;
                        overflow_reg <= 1'b0;
                        err_reg      <= 1'b0;
                    end else begin
                        src1_reg <= alu_result;
                        src2_reg <= mplier_reg[1] ? mcand_shift : '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign alu_src1         = src1_reg;
    assign alu_src2         = src2_reg;
    assign alu_ctrl         = ctrl_reg;
    assign bus.rsp_result   = result_reg;
    assign bus.rsp_zero     = zero_reg;
    assign bus.rsp_cout     = cout_reg;
    assign bus.rsp_overflow = overflow_reg;
    assign bus.rsp_err      = err_reg;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq with a behavioural 32-bit ALU wired to the alu_* ports.
module tb_alu_seq;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
        logic        c;
        logic        o;
        logic        e;
        int          lat;
        int          hold;
    } vec_t;

    typedef struct {
        vec_t v;
        int   id;
        int   acc_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] alu_src1, alu_src2, alu_result;
    logic [3:0]  alu_ctrl;
    logic        alu_zero, alu_cout, alu_overflow;
    logic [32:0] alu_sum;

    alu_seq_if bus ();

    alu_seq dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .alu_src1     (alu_src1),
        .alu_src2     (alu_src2),
        .alu_ctrl     (alu_ctrl),
        .alu_result   (alu_result),
        .alu_zero     (alu_zero),
        .alu_cout     (alu_cout),
        .alu_overflow (alu_overflow)
    );

    always #5 clk = ~clk;

    // behavioural ALU
    always_comb begin
        alu_sum      = '0;
        alu_result   = '0;
        alu_cout     = 1'b0;
        alu_overflow = 1'b0;
        case (alu_ctrl)
            4'b0000: alu_result = alu_src1 & alu_src2;
            4'b0001: alu_result = alu_src1 | alu_src2;
            4'b0010: begin
                alu_sum      = {1'b0, alu_src1} + {1'b0, alu_src2};
                alu_result   = alu_sum[31:0];
                alu_cout     = alu_sum[32];
                alu_overflow = (alu_src1[31] == alu_src2[31]) && (alu_sum[31] != alu_src1[31]);
            end
            4'b0110: begin
                alu_sum      = {1'b0, alu_src1} + {1'b0, ~alu_src2} + 33'd1;
                alu_result   = alu_sum[31:0];
                alu_cout     = alu_sum[32];
                alu_overflow = (alu_src1[31] != alu_src2[31]) && (alu_sum[31] != alu_src1[31]);
            end
            4'b0111: alu_result = {31'b0, ($signed(alu_src1) < $signed(alu_src2))};
            4'b1100: alu_result = ~(alu_src1 | alu_src2);
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t exp_q[$];
    vec_t vecs[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] res, input logic z, input logic c, input logic o,
                           input logic e, input int lat, input int hold);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.res = res;
        v.z = z; v.c = c; v.o = o; v.e = e; v.lat = lat; v.hold = hold;
        vecs.push_back(v);
    endtask

    task automatic issue(input vec_t v, input int id, input bit expect_rsp);
        exp_t x;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b1;
        bus.req_op    = v.op;
        bus.req_src1  = v.a;
        bus.req_src2  = v.b;
        for (int w = 0; w < 200; w++) begin
            @(negedge clk);
            if (bus.req_ready) break;
        end
        if (!bus.req_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL req%0d accept timeout: req_ready stuck at 0, required 1", id);
        end else if (expect_rsp) begin
            x.v = v; x.id = id; x.acc_cyc = cyc + 1;
            exp_q.push_back(x);
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_op    = 3'($urandom_range(0, 7));
        bus.req_src1  = $urandom;
        bus.req_src2  = $urandom;
    endtask

    // response monitor / scoreboard
    bit          seen = 0;
    bit          have_exp = 0;
    int          hold_left = 0;
    int          first_cyc = 0;
    exp_t        cur;
    logic [31:0] snap_res;
    logic [3:0]  snap_flags;

    initial bus.rsp_ready = 1'b1;

    always @(negedge clk) begin
        if (!rst_n) begin
            seen          = 0;
            hold_left     = 0;
            bus.rsp_ready = 1'b1;
        end else if (bus.rsp_valid) begin
            if (!seen) begin
                seen       = 1;
                first_cyc  = cyc;
                snap_res   = bus.rsp_result;
                snap_flags = {bus.rsp_zero, bus.rsp_cout, bus.rsp_overflow, bus.rsp_err};
                if (exp_q.size() == 0) begin
                    have_exp = 0;
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected rsp: got result 0x%08h, required no response", bus.rsp_result);
                end else begin
                    have_exp = 1;
                    cur      = exp_q.pop_front();
                    check($sformatf("req%0d latency", cur.id), 32'(first_cyc - cur.acc_cyc + 1), 32'(cur.v.lat));
                    hold_left = cur.v.hold;
                end
            end else begin
                check($sformatf("req%0d hold result", cur.id), bus.rsp_result, snap_res);
                check($sformatf("req%0d hold flags", cur.id),
                      32'({bus.rsp_zero, bus.rsp_cout, bus.rsp_overflow, bus.rsp_err}), 32'(snap_flags));
                check($sformatf("req%0d hold req_ready", cur.id), 32'(bus.req_ready), 32'd0);
            end
            if (hold_left > 0) begin
                bus.rsp_ready = 1'b0;
                hold_left--;
            end else begin
                bus.rsp_ready = 1'b1;
                if (have_exp) begin
                    check($sformatf("req%0d result", cur.id), bus.rsp_result, cur.v.res);
                    check($sformatf("req%0d zero", cur.id), 32'(bus.rsp_zero), 32'(cur.v.z));
                    check($sformatf("req%0d cout", cur.id), 32'(bus.rsp_cout), 32'(cur.v.c));
                    check($sformatf("req%0d overflow", cur.id), 32'(bus.rsp_overflow), 32'(cur.v.o));
                    check($sformatf("req%0d err", cur.id), 32'(bus.rsp_err), 32'(cur.v.e));
                    $display("txn %0d op=%0d a=0x%08h b=0x%08h -> result=0x%08h z=%0b c=%0b o=%0b e=%0b lat=%0d",
                             cur.id, cur.v.op, cur.v.a, cur.v.b, bus.rsp_result, bus.rsp_zero,
                             bus.rsp_cout, bus.rsp_overflow, bus.rsp_err, first_cyc - cur.acc_cyc + 1);
                end
                seen = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check_all_zero(input string tag);
        check({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, " rsp_result"}, bus.rsp_result, 32'd0);
        check({tag, " rsp_flags"}, 32'({bus.rsp_zero, bus.rsp_cout, bus.rsp_overflow, bus.rsp_err}), 32'd0);
        check({tag, " alu_src1"}, alu_src1, 32'd0);
        check({tag, " alu_src2"}, alu_src2, 32'd0);
        check({tag, " alu_ctrl"}, 32'(alu_ctrl), 32'd0);
    endtask

    initial begin
        vec_t rv;
        bus.req_valid = 1'b0;
        bus.req_op    = 3'd0;
        bus.req_src1  = '0;
        bus.req_src2  = '0;

        //       op    a             b             result        z     c     o     e     lat hold
        add_vec(3'd2, 32'd7,        32'd5,        32'd12,       1'b0, 1'b0, 1'b0, 1'b0, 2,  0);
        add_vec(3'd3, 32'd5,        32'd5,        32'd0,        1'b1, 1'b1, 1'b0, 1'b0, 2,  0);
        add_vec(3'd2, 32'h7FFFFFFF, 32'd1,        32'h80000000, 1'b0, 1'b0, 1'b1, 1'b0, 2,  0);
        add_vec(3'd4, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1'b0, 1'b0, 1'b0, 2,  0);
        add_vec(3'd5, 32'd0,        32'd0,        32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 2,  0);
        add_vec(3'd0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0, 1'b0, 2,  0);
        add_vec(3'd1, 32'h000000F0, 32'h0000000F, 32'h000000FF, 1'b0, 1'b0, 1'b0, 1'b0, 2,  0);
        add_vec(3'd7, 32'h12345678, 32'h9ABCDEF0, 32'd0,        1'b0, 1'b0, 1'b0, 1'b1, 1,  0);
        add_vec(3'd6, 32'd123,      32'd456,      32'd56088,    1'b0, 1'b0, 1'b0, 1'b0, 33, 0);
        add_vec(3'd6, 32'h00010000, 32'h00010000, 32'd0,        1'b1, 1'b0, 1'b0, 1'b0, 33, 0);
        add_vec(3'd6, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b0, 33, 0);
        add_vec(3'd2, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1'b1, 1'b0, 1'b0, 2,  5);

        #12;
        check_all_zero("reset");
        check("reset req_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) issue(vecs[i], i, 1'b1);

        // MULLO 3*5 aborted by reset mid-loop; no response may ever appear for it
        rv.op = 3'd6; rv.a = 32'd3; rv.b = 32'd5; rv.res = '0;
        rv.z = 1'b0; rv.c = 1'b0; rv.o = 1'b0; rv.e = 1'b0; rv.lat = 0; rv.hold = 0;
        issue(rv, 100, 1'b0);
        repeat (9) @(posedge clk);
        #2;
        check("mul acc before reset", alu_src1, 32'd15);
        rst_n = 1'b0;
        #1;
        check_all_zero("midmul reset");
        @(negedge clk);
        rst_n = 1'b1;

        rv.op = 3'd2; rv.a = 32'd1; rv.b = 32'd1; rv.res = 32'd2;
        rv.z = 1'b0; rv.c = 1'b0; rv.o = 1'b0; rv.e = 1'b0; rv.lat = 2; rv.hold = 0;
        issue(rv, 101, 1'b1);

        for (int w = 0; w < 300; w++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !seen) break;
        end
        if (exp_q.size() != 0 || seen) begin
            n_vec++;
            n_err++;
            $display("FAIL drain timeout: %0d responses outstanding, required 0", exp_q.size());
        end
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
